// File: rtl/sum_link_rx.sv
// Receive side of the inter-core softmax sum link: drains the peer sum FIFO into the local sfp_row sum FIFO.
// Latency: peer_rd at cycle T -> wr_sum/sum_in valid at T+rd_lat+1; one word in flight, rd_lat+1 cycles/word.
// Backpressure: credit counter mirrors free slots of the local sum FIFO; no credit -> no peer read (never times out).
module sum_link_rx #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+3,
    parameter int depth   = 16,
    parameter int rd_lat  = 1,
    parameter int timeout = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [4:0]           row_cnt,
    input  logic                 peer_empty,
    input  logic [bw_psum+3:0]   peer_data,
    output logic                 peer_rd,
    input  logic                 local_rd,
    output logic [bw_psum+3:0]   sum_in,
    output logic                 wr_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 err_to,
    output logic                 err_uf
);
    localparam int CW = $clog2(depth + 1);
    localparam int TW = $clog2(timeout + 2);
    localparam int LW = 8;
    localparam logic [CW-1:0] DEPTH_V  = CW'(depth);
    localparam logic [TW-1:0] TO_V     = TW'(timeout);
    localparam logic [LW-1:0] LAT_INIT = LW'(rd_lat - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PUSH, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_credit;
    logic [4:0]      r_remaining;
    logic [TW-1:0]   r_wait_cnt;
    logic [LW-1:0]   r_lat_cnt;
    logic [TW-1:0]   w_wait_inc;
    logic            w_accept;
    logic            w_abort;

    assign w_wait_inc = r_wait_cnt + TW'(1);

    // State register; reset returns to IDLE at once, dropping any in-flight word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus the combinational strobes (peer_rd, busy, done).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        peer_rd     = (r_state == S_REQ) && !peer_empty && (r_credit != '0);
        busy        = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_PUSH);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (row_cnt == 5'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (peer_rd) begin
                    w_state_nxt = (rd_lat == 1) ? S_PUSH : S_WAIT;
                end else if (peer_empty && (timeout != 0) && (w_wait_inc == TO_V)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt <= LW'(1)) w_state_nxt = S_PUSH;
            end
            S_PUSH: begin
                w_state_nxt = (r_remaining == 5'd0) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping, output word register and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_remaining <= 5'd0;
            r_wait_cnt  <= '0;
            r_lat_cnt   <= '0;
            sum_in      <= '0;
            wr_sum      <= 1'b0;
            err_to      <= 1'b0;
            err_uf      <= 1'b0;
        end else begin
            wr_sum <= 1'b0;
            if (w_accept) begin
                r_remaining <= row_cnt;
                r_wait_cnt  <= '0;
                err_to      <= 1'b0;
                err_uf      <= 1'b0;
            end
            if (peer_rd) begin
                r_remaining <= r_remaining - 5'd1;
                r_wait_cnt  <= '0;
                r_lat_cnt   <= LAT_INIT;
            end else if ((r_state == S_REQ) && peer_empty) begin
                r_wait_cnt  <= w_wait_inc;
            end
            if (w_abort) begin
                err_to     <= 1'b1;
                r_wait_cnt <= '0;
            end
            if (r_state == S_WAIT) r_lat_cnt <= r_lat_cnt - LW'(1);
            if (r_state == S_PUSH) begin
                sum_in <= peer_data;
                wr_sum <= 1'b1;
            end
            // A pop with every slot already free means the local FIFO was read empty.
            if (local_rd && (r_credit == DEPTH_V)) err_uf <= 1'b1;
        end
    end

    // Credit counter runs in every state; simultaneous pop and issue cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit <= DEPTH_V;
        end else if (local_rd && peer_rd) begin
            r_credit <= r_credit;
        end else if (peer_rd) begin
            r_credit <= r_credit - CW'(1);
        end else if (local_rd && (r_credit != DEPTH_V)) begin
            r_credit <= r_credit + CW'(1);
        end
    end
endmodule

// File: tb/tb_sum_link_rx.sv
module tb_sum_link_rx;
    localparam int DW = 23;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [4:0]    row_cnt;
    logic          peer_empty;
    logic [DW-1:0] peer_data;
    logic          peer_rd;
    logic          local_rd;
    logic [DW-1:0] sum_in;
    logic          wr_sum;
    logic          busy;
    logic          done;
    logic          err_to;
    logic          err_uf;

    int total = 0;
    int bad   = 0;

    // peer FIFO model: 1-cycle read latency
    logic [DW-1:0] mem [64];
    int rp = 0;
    int wp = 0;

    always #5 clk = ~clk;

    sum_link_rx #(.bw(8), .depth(16), .rd_lat(1), .timeout(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .row_cnt(row_cnt),
        .peer_empty(peer_empty), .peer_data(peer_data), .peer_rd(peer_rd),
        .local_rd(local_rd), .sum_in(sum_in), .wr_sum(wr_sum), .busy(busy),
        .done(done), .err_to(err_to), .err_uf(err_uf)
    );

    assign peer_empty = (rp == wp);

    always @(posedge clk) begin
        if (peer_rd) begin
            peer_data <= mem[rp];
            rp <= rp + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic pulse_rd();
        local_rd = 1'b1;
        tick();
        local_rd = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] n);
        row_cnt = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nw;
        int npr;
        logic seen_done;
        logic [DW-1:0] last;
        logic [DW-1:0] exp_w;

        rstn = 1'b0; start = 1'b0; row_cnt = 5'd0; local_rd = 1'b0;
        peer_data = '0;
        tick(); tick();
        chk("rst_peer_rd", {31'd0, peer_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_sum", {31'd0, wr_sum}, 32'd0);
        chk("rst_sum_in", 32'(sum_in), 32'd0);
        chk("rst_errs", {30'd0, err_to, err_uf}, 32'd0);
        rstn = 1'b1;
        tick();

        // 1) four words, peer never empty: 2 cycles per word
        push_word(23'h11); push_word(23'h22); push_word(23'h33); push_word(23'h44);
        do_start(5'd4);
        for (int k = 0; k <= 9; k++) begin
            chk($sformatf("r1_peer_rd_k%0d", k), {31'd0, peer_rd}, {31'd0, (k < 8) && (k % 2 == 0)});
            chk($sformatf("r1_wr_sum_k%0d", k), {31'd0, wr_sum}, {31'd0, (k >= 2) && (k <= 8) && (k % 2 == 0)});
            chk($sformatf("r1_done_k%0d", k), {31'd0, done}, {31'd0, k == 8});
            chk($sformatf("r1_busy_k%0d", k), {31'd0, busy}, {31'd0, k < 8});
            if ((k >= 2) && (k <= 8) && (k % 2 == 0)) begin
                exp_w = 23'h11 * 23'(k / 2);
                chk($sformatf("r1_sum_in_k%0d", k), 32'(sum_in), 32'(exp_w));
            end
            tick();
        end

        // credit should now be 12: four returns are clean, the fifth underflows
        for (int i = 0; i < 4; i++) pulse_rd();
        chk("cr12_no_uf", {31'd0, err_uf}, 32'd0);
        pulse_rd();
        chk("cr12_uf", {31'd0, err_uf}, 32'd1);

        // 2) sixteen words drain all credit
        for (int i = 0; i < 16; i++) push_word(23'h100 + 23'(i));
        do_start(5'd16);
        chk("r2_uf_cleared", {31'd0, err_uf}, 32'd0);
        nw = 0; seen_done = 1'b0; last = '0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            if (wr_sum) begin nw++; last = sum_in; end
            if (done) seen_done = 1'b1;
            else tick();
        end
        chk("r2_done_seen", {31'd0, seen_done}, 32'd1);
        chk("r2_nwords", 32'(nw), 32'd16);
        chk("r2_last", 32'(last), 32'h10f);
        tick();

        // one more word: stalls on credit, no timeout
        push_word(23'h1ab);
        do_start(5'd1);
        npr = 0;
        for (int c = 0; c < 20; c++) begin
            if (peer_rd) npr++;
            tick();
        end
        chk("stall_peer_rd", 32'(npr), 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_no_err_to", {31'd0, err_to}, 32'd0);
        local_rd = 1'b1;
        tick();
        local_rd = 1'b0;
        chk("credit_ret_peer_rd", {31'd0, peer_rd}, 32'd1);
        tick(); tick();
        chk("w17_wr_sum", {31'd0, wr_sum}, 32'd1);
        chk("w17_sum_in", 32'(sum_in), 32'h1ab);
        chk("w17_done", {31'd0, done}, 32'd1);
        tick();

        // 4) credit 5, pop and issue in the same cycle
        for (int i = 0; i < 5; i++) pulse_rd();
        push_word(23'h55);
        do_start(5'd1);
        chk("c5_peer_rd", {31'd0, peer_rd}, 32'd1);
        local_rd = 1'b1;
        tick();
        local_rd = 1'b0;
        tick();
        chk("c5_wr_sum", {31'd0, wr_sum}, 32'd1);
        chk("c5_sum_in", 32'(sum_in), 32'h55);
        tick();
        for (int i = 0; i < 11; i++) pulse_rd();
        chk("c5_no_uf_at16", {31'd0, err_uf}, 32'd0);
        pulse_rd();
        chk("c5_uf", {31'd0, err_uf}, 32'd1);

        // 5) reset with a word in flight
        push_word(23'h66);
        do_start(5'd2);
        chk("inflight_peer_rd", {31'd0, peer_rd}, 32'd1);
        tick();
        rstn = 1'b0;
        #1;
        chk("arst_peer_rd", {31'd0, peer_rd}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_wr_sum", {31'd0, wr_sum}, 32'd0);
        chk("arst_sum_in", 32'(sum_in), 32'd0);
        chk("arst_err_uf", {31'd0, err_uf}, 32'd0);
        tick(); tick();
        rstn = 1'b1;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (wr_sum) nw++;
        end
        chk("arst_no_wr_after", 32'(nw), 32'd0);

        // 3) peer empty, timeout 8
        do_start(5'd2);
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_pending_k%0d", k), {30'd0, err_to, done}, 32'd0);
            if (wr_sum) nw++;
            tick();
        end
        chk("to_err_to", {31'd0, err_to}, 32'd1);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_no_wr", 32'(nw + int'(wr_sum)), 32'd0);
        tick();
        chk("to_sticky", {31'd0, err_to}, 32'd1);
        chk("to_done_pulse", {31'd0, done}, 32'd0);

        // row_cnt == 0: immediate done, no read
        do_start(5'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_peer_rd", {31'd0, peer_rd}, 32'd0);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_err_to_clr", {31'd0, err_to}, 32'd0);
        tick();
        chk("z_done_end", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
